mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 48 ++++
 rtl/mem_access_ctrl_lane_align.sv | 50 +++++
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store access controller: size codes, FSM states,
// the latched request record, and address alignment/error helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic        err;
    } req_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] a;
        case (size)
            SZ_HALF: a = {addr[31:1], 1'b0};
            SZ_WORD: a = {addr[31:2], 2'b00};
            default: a = addr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Big-endian lane steering: extracts/extends a load from a memory word and
// merges right-justified store data into the addressed lanes of a word.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[15:0] : word[31:16];

        ld_data = word;
        st_word = wdata;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
                st_word = word;
                case (off)
                    2'd0:    st_word[31:24] = wdata[7:0];
                    2'd1:    st_word[23:16] = wdata[7:0];
                    2'd2:    st_word[15:8]  = wdata[7:0];
                    default: st_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                ld_data = {{16{sgn & half_sel[15]}}, half_sel};
                st_word = word;
                if (off[1]) st_word[15:0]  = wdata[15:0];
                else        st_word[31:16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store controller over a word-wide synchronous data memory, with
// read-modify-write for sub-word stores. Build option: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    req_t        req_q, req_d, new_req;
    logic [31:0] acc_addr;
    logic [31:0] buf_q, buf_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] ld_data, st_word;

    always_comb begin
        new_req.we    = req_we;
        new_req.sgn   = req_signed;
        new_req.wdata = req_wdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        new_req.size  = req_size;
        acc_addr      = req_addr;
        new_req.err   = misaligned(req_size, req_addr[1:0]);
`else
        // Without trapping, reserved size acts as word and low bits are dropped.
        new_req.size  = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
        acc_addr      = align_addr(new_req.size, req_addr);
        new_req.err   = 1'b0;
`endif
        new_req.off   = acc_addr[1:0];
    end

    // The word seen by lane_align is the live read data during CAP so the
    // load result and merged store word are ready on the CAP exit edge.
    assign buf_d = (state_q == CAP) ? mem_rdata : buf_q;

    lane_align u_lane_align (
        .size    (req_q.size),
        .sgn     (req_q.sgn),
        .off     (req_q.off),
        .word    (buf_d),
        .wdata   (req_q.wdata),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    req_d = new_req;
                    if (new_req.err) begin
                        state_d = RSP;
                    end else begin
                        mem_addr_d = {acc_addr[31:2], 2'b00};
                        if (new_req.we && new_req.size == SZ_WORD) begin
                            mem_wdata_d = new_req.wdata;
                            state_d     = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (req_q.we) begin
                    mem_wdata_d = st_word;
                    state_d     = WR;
                end else begin
                    resp_rdata_d = ld_data;
                    state_d      = RSP;
                end
            end
            WR:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered against the next state so they line up with it.
        ready_d      = (state_d == IDLE);
        mem_wr_d     = (state_d == WR);
        resp_valid_d = (state_d == RSP);
        resp_err_d   = (state_d == RSP) && req_d.err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            buf_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            buf_q        <= buf_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed requests push expected responses
// and memory writes; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_wr;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    // Synchronous-read data memory; pre reloads the standard image.
    logic [31:0] mem [0:63];
    logic [31:0] mem_rdata_r = '0;
    logic        pre = 1'b0;
    assign mem_rdata = mem_rdata_r;
    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        mem_rdata_r <= mem[mem_addr[7:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];
    int checks = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (rst_n) begin
            if (resp_valid) begin
                if (rq.size() == 0) fail_now("unexpected_resp");
                else begin
                    e = rq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    chk("resp_latency", cyc - e.acc + 1, e.lat);
                    chk("ready_low_in_rsp", {31'b0, req_ready}, 32'd0);
                end
            end
            if (mem_wr) begin
                if (wq.size() == 0) fail_now("unexpected_mem_wr");
                else begin
                    w = wq.pop_front();
                    chk("mem_addr", mem_addr, w.addr);
                    chk("mem_wdata", mem_wdata, w.data);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input logic has_wr, input logic [31:0] wa, input logic [31:0] wdx,
                         input logic hold, output int acc);
        int n = 0;
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        rq.push_back('{exp_rd, exp_err, lat, acc});
        if (has_wr) wq.push_back('{wa, wdx});
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) fail_now("idle_timeout");
        @(negedge clk);
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_err);
        int acc;
        issue(1'b0, sz, sg, a, 32'h0, exp_err ? 32'h0 : exp_rd, exp_err, exp_err ? 1 : 3,
              1'b0, 32'h0, 32'h0, 1'b0, acc);
        wait_idle();
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] wa, input logic [31:0] wdx, input logic exp_err);
        int acc;
        issue(1'b1, sz, 1'b0, a, wd, 32'h0, exp_err, exp_err ? 1 : (sz == W ? 2 : 4),
              !exp_err, wa, wdx, 1'b0, acc);
        wait_idle();
    endtask

    task automatic preload();
        @(negedge clk); pre = 1'b1;
        @(negedge clk); pre = 1'b0;
    endtask

    initial begin
        int acc1, acc2;
        preload();
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        st(W, 32'h10, 32'h11223344, 32'h10, 32'h11223344, 1'b0);
        chk("mem10_after_sw", mem[4], 32'h11223344);

        preload();
        ld(B, 1'b1, 32'h11, 32'hFFFFFF99, 1'b0);
        ld(B, 1'b0, 32'h11, 32'h00000099, 1'b0);
        st(H, 32'h12, 32'h0000CAFE, 32'h10, 32'h8899CAFE, 1'b0);
        ld(W, 1'b0, 32'h10, 32'h8899CAFE, 1'b0);

        preload();
        ld(H, 1'b1, 32'h11, 32'hFFFF8899, TRAP);
        ld(B, 1'b1, 32'h10, 32'hFFFFFF88, 1'b0);
        ld(B, 1'b1, 32'h13, 32'hFFFFFFBB, 1'b0);
        ld(B, 1'b0, 32'h12, 32'h000000AA, 1'b0);
        ld(H, 1'b0, 32'h12, 32'h0000AABB, 1'b0);
        ld(H, 1'b1, 32'h12, 32'hFFFFAABB, 1'b0);
        st(B, 32'h10, 32'hFFFFFF55, 32'h10, 32'h5599AABB, 1'b0);
        st(B, 32'h13, 32'h00000077, 32'h10, 32'h5599AA77, 1'b0);
        st(H, 32'h10, 32'hABCD1234, 32'h10, 32'h1234AA77, 1'b0);
        ld(W, 1'b0, 32'h13, 32'h1234AA77, TRAP);
        ld(R, 1'b0, 32'h10, 32'h1234AA77, TRAP);
        st(W, 32'h12, 32'hCAFEBABE, 32'h10, 32'hCAFEBABE, TRAP);
        chk("mem10_after_misaligned_sw", mem[4], TRAP ? 32'h1234AA77 : 32'hCAFEBABE);

        // Reset during CAP of a sub-word store must abort it without a write.
        preload();
        req_we = 1'b1; req_size = B; req_signed = 1'b0; req_addr = 32'h13; req_wdata = 32'h55;
        req_valid = 1'b1;
        while (!req_ready) @(negedge clk);
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("postrst_ready", {31'b0, req_ready}, 32'd1);
        chk("postrst_mem10", mem[4], 32'h8899AABB);

        // Back-to-back with req_valid held: second accept waits for the first to finish.
        issue(1'b0, W, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 1'b0, 32'h0, 32'h0, 1'b1, acc1);
        issue(1'b1, W, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 32'h14, 32'hDEADBEEF,
              1'b0, acc2);
        chk("b2b_accept_edge", acc2, acc1 + 4);
        wait_idle();
        chk("mem14_after_b2b", mem[5], 32'hDEADBEEF);
        chk("mem10_after_b2b", mem[4], 32'h8899AABB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fail_now("watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
